// File: rtl/uart_frame_assembler.sv
// Frame parser (sync, length, payload, optional checksum) packing UART bytes little-endian into words behind a small FIFO.
// Optional checksum byte after the payload is enabled by defining UART_FRAME_CHECKSUM_EN.
`timescale 1ns/1ps
module uart_frame_assembler #(
  parameter int unsigned          DATA_SIZE  = 8,
  parameter int unsigned          WORD_BYTES = 4,
  parameter int unsigned          FIFO_DEPTH = 8,
  parameter logic [DATA_SIZE-1:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [DATA_SIZE-1:0]            data_in,
  input  logic                            new_data_in,
  output logic [DATA_SIZE*WORD_BYTES-1:0] word_out,
  output logic                            last_out,
  output logic                            word_valid_out,
  input  logic                            word_ready_in,
  output logic                            frame_error_out,
  output logic                            overflow_out,
  output logic                            busy_out
);

  localparam int unsigned WORD_W = DATA_SIZE * WORD_BYTES;
  localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_LEN,
    ST_PAYLOAD
`ifdef UART_FRAME_CHECKSUM_EN
    , ST_CHK
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_SIZE-1:0] rem_q, rem_d;
  logic [WORD_W-1:0]    acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [DATA_SIZE-1:0] chk_q, chk_d;
  logic                 frame_err_q, frame_err_d;
`endif

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WORD_W-1:0]    mem_q [FIFO_DEPTH];
  logic                 last_mem_q [FIFO_DEPTH];

  logic push_req, push_last, push_ok, push_en, pop;

  assign word_valid_out = (count_q != '0);
  assign pop            = word_valid_out && word_ready_in;
  assign push_ok        = (count_q < CNT_W'(FIFO_DEPTH)) || pop;
  assign push_en        = push_req && push_ok;

  // Parser: the word being completed is pushed from acc_d in the same cycle its final byte arrives.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    ovf_d     = 1'b0;
    push_req  = 1'b0;
    push_last = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    chk_d       = chk_q;
    frame_err_d = 1'b0;
`endif
    if (new_data_in) begin
      unique case (state_q)
        ST_SYNC: begin
          if (data_in == SYNC_BYTE) begin
            state_d = ST_LEN;
            idx_d   = '0;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_d = '0;
`endif
          end
        end
        ST_LEN: begin
`ifdef UART_FRAME_CHECKSUM_EN
          chk_d = chk_q ^ data_in;
`endif
          idx_d = '0;
          if (data_in == '0) begin
            state_d = ST_SYNC;
          end else begin
            rem_d   = data_in;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
`ifdef UART_FRAME_CHECKSUM_EN
          chk_d = chk_q ^ data_in;
`endif
          acc_d[idx_q*DATA_SIZE +: DATA_SIZE] = data_in;
          if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
            idx_d     = '0;
            push_req  = 1'b1;
            push_last = (rem_q == DATA_SIZE'(1));
            rem_d     = rem_q - DATA_SIZE'(1);
            if (!push_ok) begin
              ovf_d   = 1'b1;
              state_d = ST_SYNC;
            end else if (rem_q == DATA_SIZE'(1)) begin
`ifdef UART_FRAME_CHECKSUM_EN
              state_d = ST_CHK;
`else
              state_d = ST_SYNC;
`endif
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        ST_CHK: begin
          frame_err_d = (data_in != chk_q);
          state_d     = ST_SYNC;
        end
`endif
        default: state_d = ST_SYNC;
      endcase
    end
    busy_d = (state_d != ST_SYNC);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_en && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_SYNC;
      idx_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q       <= '0;
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q       <= chk_d;
      frame_err_q <= frame_err_d;
`endif
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && push_en) begin
      mem_q[wr_ptr_q]      <= acc_d;
      last_mem_q[wr_ptr_q] <= push_last;
    end
  end

  assign word_out     = word_valid_out ? mem_q[rd_ptr_q] : '0;
  assign last_out     = word_valid_out ? last_mem_q[rd_ptr_q] : 1'b0;
  assign overflow_out = ovf_q;
  assign busy_out     = busy_q;
`ifdef UART_FRAME_CHECKSUM_EN
  assign frame_error_out = frame_err_q;
`else
  assign frame_error_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Self-checking bench for uart_frame_assembler: scoreboard of expected words plus table-driven single-word frames.
`timescale 1ns/1ps
module tb_uart_frame_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        new_data_in;
  logic [31:0] word_out;
  logic        last_out;
  logic        word_valid_out;
  logic        word_ready_in;
  logic        frame_error_out;
  logic        overflow_out;
  logic        busy_out;

  uart_frame_assembler #(
    .DATA_SIZE (8),
    .WORD_BYTES(4),
    .FIFO_DEPTH(8),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .data_in        (data_in),
    .new_data_in    (new_data_in),
    .word_out       (word_out),
    .last_out       (last_out),
    .word_valid_out (word_valid_out),
    .word_ready_in  (word_ready_in),
    .frame_error_out(frame_error_out),
    .overflow_out   (overflow_out),
    .busy_out       (busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_word;
  } vec_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         fe_cnt = 0;
  int         ovf_cnt = 0;
  int         exp_fe = 0;
  logic [7:0] pl[64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (frame_error_out) fe_cnt++;
      if (overflow_out)    ovf_cnt++;
      if (word_valid_out && word_ready_in) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h last %b, required no word", word_out, last_out);
        end else begin
          e = sb.pop_front();
          check("word", {32'h0, word_out}, {32'h0, e.word});
          check("last", {63'h0, last_out}, {63'h0, e.last});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    data_in     = b;
    new_data_in = 1'b1;
    tick();
    new_data_in = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input logic [7:0] len, input int n, input int gap, input bit with_chk);
    logic [7:0] chk;
    chk = len;
    send_byte(8'hA5, gap);
    send_byte(len, gap);
    for (int i = 0; i < n; i++) begin
      chk ^= pl[i];
      send_byte(pl[i], gap);
    end
`ifdef UART_FRAME_CHECKSUM_EN
    if (with_chk) send_byte(chk, gap);
`else
    if (with_chk) chk = 8'h00;
`endif
  endtask

  task automatic push_exp(input logic [31:0] w, input logic l);
    exp_t e;
    e.word = w;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {63'h0, word_valid_out}, 64'd0);
    check({tag, "_word"},  {32'h0, word_out}, 64'd0);
    check({tag, "_last"},  {63'h0, last_out}, 64'd0);
    check({tag, "_fe"},    {63'h0, frame_error_out}, 64'd0);
    check({tag, "_ovf"},   {63'h0, overflow_out}, 64'd0);
    check({tag, "_busy"},  {63'h0, busy_out}, 64'd0);
  endtask

  vec_t vecs[3];

  initial begin
    int ovf0;
    vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF};
    vecs[2] = '{8'hA5, 8'hA5, 8'h5A, 8'h5A, 32'h5A5AA5A5};

    rst_n = 1'b0; data_in = '0; new_data_in = 1'b0; word_ready_in = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Two-word frame, back-to-back bytes
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    pl[4] = 8'h55; pl[5] = 8'h66; pl[6] = 8'h77; pl[7] = 8'h88;
    push_exp(32'h44332211, 1'b0);
    push_exp(32'h88776655, 1'b1);
    send_frame(8'h02, 8, 0, 1'b1);
    check("busy_after_frame", {63'h0, busy_out}, 64'd0);
    wait_drain("drain_two_word");

    // Table of single-word frames, including payload bytes equal to the sync marker
    for (int v = 0; v < 3; v++) begin
      pl[0] = vecs[v].b0; pl[1] = vecs[v].b1; pl[2] = vecs[v].b2; pl[3] = vecs[v].b3;
      push_exp(vecs[v].exp_word, 1'b1);
      send_frame(8'h01, 4, 1, 1'b1);
    end
    wait_drain("drain_table");

    // Leading garbage and sparse strobes; valid rises right after the completing strobe
    send_byte(8'h00, 10);
    send_byte(8'h13, 10);
    check("busy_after_garbage", {63'h0, busy_out}, 64'd0);
    send_byte(8'hA5, 10);
    send_byte(8'h01, 10);
    send_byte(8'hDE, 10);
    send_byte(8'hAD, 10);
    send_byte(8'hBE, 10);
    push_exp(32'hEFBEADDE, 1'b1);
    data_in = 8'hEF;
    new_data_in = 1'b1;
    check("valid_before_strobe", {63'h0, word_valid_out}, 64'd0);
    tick();
    new_data_in = 1'b0;
    check("valid_after_strobe", {63'h0, word_valid_out}, 64'd1);
    check("word_after_strobe", {32'h0, word_out}, {32'h0, 32'hEFBEADDE});
`ifdef UART_FRAME_CHECKSUM_EN
    repeat (3) tick();
    send_byte(8'h01 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 2);
`endif
    wait_drain("drain_sparse");

    // Overflow: nine words into an eight-entry FIFO with the consumer stalled
    word_ready_in = 1'b0;
    for (int i = 0; i < 36; i++) pl[i] = 8'(i + 1);
    for (int w = 0; w < 8; w++)
      push_exp({pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]}, 1'b0);
    ovf0 = ovf_cnt;
    send_frame(8'h09, 36, 0, 1'b0);
    check("busy_after_overflow", {63'h0, busy_out}, 64'd0);
    repeat (3) tick();
    check("overflow_pulses", 64'(ovf_cnt - ovf0), 64'd1);
    check("hold_word", {32'h0, word_out}, {32'h0, 32'h04030201});
    word_ready_in = 1'b1;
    wait_drain("drain_overflow");
    check("empty_after_drain", {63'h0, word_valid_out}, 64'd0);

`ifdef UART_FRAME_CHECKSUM_EN
    // Bad checksum: word still delivered, one error pulse
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    push_exp(32'h04030201, 1'b1);
    send_frame(8'h01, 4, 0, 1'b0);
    send_byte(8'hFF, 3);
    exp_fe++;
    check("fe_count_bad_chk", 64'(fe_cnt), 64'(exp_fe));
    wait_drain("drain_bad_chk");
`endif

    // Reset in the middle of a frame
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    check("busy_mid_frame", {63'h0, busy_out}, 64'd1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC; pl[3] = 8'hDD;
    push_exp(32'hDDCCBBAA, 1'b1);
    send_frame(8'h01, 4, 0, 1'b1);
    wait_drain("drain_after_reset");

    // Zero-length frame followed by a normal one
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    check("busy_after_len0", {63'h0, busy_out}, 64'd0);
    pl[0] = 8'h01; pl[1] = 8'h00; pl[2] = 8'h00; pl[3] = 8'h00;
    push_exp(32'h00000001, 1'b1);
    send_frame(8'h01, 4, 0, 1'b1);
    wait_drain("drain_len0");

    repeat (3) tick();
    check("fe_count_total", 64'(fe_cnt), 64'(exp_fe));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
